// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: widths, NOP encoding and fetch-stage state.
package cpu_pkg;

  localparam int unsigned PC_W    = 22;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic {
    IF_RUN,
    IF_HALTED
  } if_state_e;

endpackage

// File: rtl/if_pc_gen.sv
// Program counter register with hold / increment / redirect next-PC selection.
// Increment wraps modulo 2^PC_WIDTH.
module if_pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_WIDTH = PC_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_pc,
  input  logic                advance,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (advance) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register and RUN/HALTED control.
// Optional IF_PERF_CNT_EN adds saturating fetch and bubble counters.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned            PC_WIDTH    = PC_W,
  parameter int unsigned            INSTR_WIDTH = INSTR_W,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IF_stall,
  input  logic                   EX_redirect,
  input  logic [PC_WIDTH-1:0]    EX_redirect_pc,
  input  logic                   EX_hlt,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_rd,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] ID_instr,
  output logic [PC_WIDTH-1:0]    ID_pc_plus1,
  output logic                   ID_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]            IF_fetch_cnt,
  output logic [31:0]            IF_bubble_cnt,
`endif
  output logic                   IF_halted
);

  if_state_e           state;
  logic [PC_WIDTH-1:0] pc;
  logic                run;
  logic                do_halt, do_redirect, do_fetch;

  assign run         = (state == IF_RUN);
  assign do_halt     = run && EX_hlt;
  assign do_redirect = run && !EX_hlt && EX_redirect;
  assign do_fetch    = run && !EX_hlt && !EX_redirect && !IF_stall;

  if_pc_gen #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (do_redirect),
    .load_pc (EX_redirect_pc),
    .advance (do_fetch),
    .pc      (pc)
  );

  assign imem_addr = pc;
  assign imem_rd   = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IF_RUN;
      ID_instr    <= INSTR_WIDTH'(NOP_INSTR);
      ID_pc_plus1 <= '0;
      ID_valid    <= 1'b0;
      IF_halted   <= 1'b0;
    end else if (do_halt) begin
      state     <= IF_HALTED;
      IF_halted <= 1'b1;
      ID_instr  <= INSTR_WIDTH'(NOP_INSTR);
      ID_valid  <= 1'b0;
    end else if (do_redirect) begin
      ID_instr <= INSTR_WIDTH'(NOP_INSTR);
      ID_valid <= 1'b0;
    end else if (do_fetch) begin
      ID_instr    <= imem_rdata;
      ID_pc_plus1 <= pc + PC_WIDTH'(1);
      ID_valid    <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic bubble_evt;

  // A stall only counts as a bubble cycle when the held IF/ID entry is already a bubble.
  assign bubble_evt = do_halt || do_redirect || (run && IF_stall && !ID_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      IF_fetch_cnt  <= '0;
      IF_bubble_cnt <= '0;
    end else begin
      if (do_fetch && (IF_fetch_cnt != 32'hFFFF_FFFF)) begin
        IF_fetch_cnt <= IF_fetch_cnt + 32'd1;
      end
      if (bubble_evt && (IF_bubble_cnt != 32'hFFFF_FFFF)) begin
        IF_bubble_cnt <= IF_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed plus randomized bench for if_fetch_stage against a cycle-level reference model.
module tb_if_fetch_stage;

  localparam int PCW  = 22;
  localparam int IW   = 32;
  localparam int PMOD = 1 << PCW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            IF_stall = 1'b0;
  logic            EX_redirect = 1'b0;
  logic [PCW-1:0]  EX_redirect_pc = '0;
  logic            EX_hlt = 1'b0;
  logic [PCW-1:0]  imem_addr;
  logic            imem_rd;
  logic [IW-1:0]   imem_rdata;
  logic [IW-1:0]   ID_instr;
  logic [PCW-1:0]  ID_pc_plus1;
  logic            ID_valid;
  logic            IF_halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     IF_fetch_cnt;
  logic [31:0]     IF_bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          m_pc;
  logic [31:0] m_instr;
  int          m_pc1;
  bit          m_valid;
  bit          m_halted;
  int          m_fetch_cnt;
  int          m_bubble_cnt;

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_f(input int a);
    return IW'(a) + 32'h100;
  endfunction

  assign imem_rdata = mem_f(int'(imem_addr));

  if_fetch_stage #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .RESET_PC    ('0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_stall       (IF_stall),
    .EX_redirect    (EX_redirect),
    .EX_redirect_pc (EX_redirect_pc),
    .EX_hlt         (EX_hlt),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .imem_rdata     (imem_rdata),
    .ID_instr       (ID_instr),
    .ID_pc_plus1    (ID_pc_plus1),
    .ID_valid       (ID_valid),
`ifdef IF_PERF_CNT_EN
    .IF_fetch_cnt   (IF_fetch_cnt),
    .IF_bubble_cnt  (IF_bubble_cnt),
`endif
    .IF_halted      (IF_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
    chk({tag, ".imem_rd"}, 32'(imem_rd), 32'(!m_halted));
    chk({tag, ".ID_instr"}, ID_instr, m_instr);
    chk({tag, ".ID_pc_plus1"}, 32'(ID_pc_plus1), 32'(m_pc1));
    chk({tag, ".ID_valid"}, 32'(ID_valid), 32'(m_valid));
    chk({tag, ".IF_halted"}, 32'(IF_halted), 32'(m_halted));
  endtask

  // Apply one cycle of inputs, advance the model by the spec's priority rules, then compare.
  task automatic step(input string tag, input bit r, input bit st, input bit rd,
                      input int tgt, input bit h);
    rst = r; IF_stall = st; EX_redirect = rd; EX_redirect_pc = PCW'(tgt); EX_hlt = h;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc1 = 0; m_valid = 0; m_halted = 0;
      m_fetch_cnt = 0; m_bubble_cnt = 0;
    end else if (!m_halted) begin
      if (h) begin
        m_halted = 1; m_valid = 0; m_instr = 0; m_bubble_cnt++;
      end else if (rd) begin
        m_pc = tgt % PMOD; m_valid = 0; m_instr = 0; m_bubble_cnt++;
      end else if (st) begin
        if (!m_valid) m_bubble_cnt++;
      end else begin
        m_instr = mem_f(m_pc); m_pc = (m_pc + 1) % PMOD; m_pc1 = m_pc; m_valid = 1;
        m_fetch_cnt++;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset
    step("reset0", 1, 0, 0, 0, 0);
    step("reset1", 1, 1, 1, 7, 1);
    // Sequential fetch 0x100..0x103, then one more to reach PC=5
    for (int i = 0; i < 5; i++) step("seq", 0, 0, 0, 0, 0);
    chk("seq.pc5", 32'(imem_addr), 32'd5);
    // Stall 3 cycles at PC=5, then resume
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 0, 0);
    step("resume", 0, 0, 0, 0, 0);
    chk("resume.instr", ID_instr, 32'h105);
    // Redirect wins over stall
    step("redir_stall", 0, 1, 1, 'h2A, 0);
    chk("redir_stall.addr", 32'(imem_addr), 32'h2A);
    step("redir_tgt", 0, 0, 0, 0, 0);
    chk("redir_tgt.instr", ID_instr, 32'h12A);
    // Halt at PC=9, ignoring redirects and stalls for 10 cycles
    step("to9", 0, 0, 1, 9, 0);
    step("halt", 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      step("halted", 0, $urandom_range(0, 1), (i % 2) == 0, $urandom_range(0, PMOD - 1), 0);
    chk("halted.pc9", 32'(imem_addr), 32'd9);
    step("halt_rst", 1, 0, 0, 0, 0);
    // Wrap at top of the address space
    step("wrap_redir", 0, 0, 1, PMOD - 1, 0);
    step("wrap_fetch", 0, 0, 0, 0, 0);
    chk("wrap.addr0", 32'(imem_addr), 32'd0);
    chk("wrap.pc1", 32'(ID_pc_plus1), 32'd0);
    step("wrap_next", 0, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int p = $urandom_range(0, 99);
      step("rand", p < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           ($urandom_range(0, 7) == 0) ? PMOD - 1 : $urandom_range(0, PMOD - 1),
           p >= 2 && p < 4);
    end
`ifdef IF_PERF_CNT_EN
    chk("perf.fetch", IF_fetch_cnt, 32'(m_fetch_cnt));
    chk("perf.bubble", IF_bubble_cnt, 32'(m_bubble_cnt));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
